// File: rtl/alu_seq16_if.sv
// Bundles the request/response handshake and the byte-ALU drive of alu_seq16.
// The slave modport is the sequencer's view; master is the requester/ALU side.
interface alu_seq16_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic        rsp_page_cross;
    logic        rsp_carry;
    logic        rsp_ovf;
    logic        rsp_err;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [7:0]  alu_res;
    logic        alu_carry;

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, rsp_ready, alu_res, alu_carry,
        output req_ready, rsp_valid, rsp_res, rsp_page_cross, rsp_carry, rsp_ovf, rsp_err,
        output alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_cmd, req_a, req_b, rsp_ready, alu_res, alu_carry,
        input  req_ready, rsp_valid, rsp_res, rsp_page_cross, rsp_carry, rsp_ovf, rsp_err,
        input  alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit add/logic sequencer built on an external 8-bit one-hot-opcode ALU:
// low-byte pass, high-byte pass, and a +1 fix pass when the low byte carried.
module alu_seq16 (
    input  logic         clk,
    input  logic         rst,
    alu_seq16_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_RESP} state_t;

    localparam logic [4:0] OP_SUM = 5'b10000;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b00100;
    localparam logic [4:0] OP_EOR = 5'b00010;

    localparam logic [2:0] CMD_ADD16  = 3'd0;
    localparam logic [2:0] CMD_ADDREL = 3'd1;
    localparam logic [2:0] CMD_AND16  = 3'd2;
    localparam logic [2:0] CMD_OR16   = 3'd3;
    localparam logic [2:0] CMD_EOR16  = 3'd4;

    function automatic logic [4:0] f_alu_op(input logic [2:0] cmd);
        case (cmd)
            CMD_AND16: f_alu_op = OP_AND;
            CMD_OR16:  f_alu_op = OP_OR;
            CMD_EOR16: f_alu_op = OP_EOR;
            default:   f_alu_op = OP_SUM;
        endcase
    endfunction

    function automatic logic f_is_add(input logic [2:0] cmd);
        f_is_add = (cmd == CMD_ADD16) || (cmd == CMD_ADDREL);
    endfunction

    state_t      r_state;
    logic [2:0]  r_cmd;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [7:0]  r_res_lo;
    logic        r_c_lo;
    logic        r_c_hi;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [4:0]  r_alu_op;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_res;
    logic        r_rsp_pc;
    logic        r_rsp_carry;
    logic        r_rsp_ovf;
    logic        r_rsp_err;

    logic        w_is_add;
    logic        w_need_fix;
    logic        w_c_hi;
    logic [15:0] w_res;
    logic        w_pc;
    logic        w_carry;
    logic        w_ovf;

    // Final result and flags as they will stand when leaving HI or FIX.
    always_comb begin
        w_is_add   = f_is_add(r_cmd);
        w_need_fix = w_is_add & r_c_lo;
        if (r_state == S_FIX) begin
            w_c_hi = r_c_hi | bus.alu_carry;
        end else begin
            w_c_hi = bus.alu_carry;
        end
        w_res   = {bus.alu_res, r_res_lo};
        w_pc    = 1'b0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_cmd)
            CMD_ADD16: begin
                w_pc    = r_c_lo;
                w_carry = w_c_hi;
                w_ovf   = (r_a[15] == r_b[15]) && (w_res[15] != r_a[15]);
            end
            CMD_ADDREL: begin
                w_pc = (w_res[15:8] != r_a[15:8]);
            end
            default: begin
                w_pc = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; every output is a register loaded on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd       <= 3'd0;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_res_lo    <= 8'h00;
            r_c_lo      <= 1'b0;
            r_c_hi      <= 1'b0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_op    <= OP_SUM;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= 16'h0000;
            r_rsp_pc    <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_cmd       <= bus.req_cmd;
                        r_a         <= bus.req_a;
                        r_b         <= (bus.req_cmd == CMD_ADDREL) ?
                                       {{8{bus.req_b[7]}}, bus.req_b[7:0]} : bus.req_b;
                        r_req_ready <= 1'b0;
                        if (bus.req_cmd <= CMD_EOR16) begin
                            r_state  <= S_LO;
                            r_alu_a  <= bus.req_a[7:0];
                            r_alu_b  <= bus.req_b[7:0];
                            r_alu_op <= f_alu_op(bus.req_cmd);
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_res   <= 16'hFFFF;
                            r_rsp_err   <= 1'b1;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_LO: begin
                    r_res_lo <= bus.alu_res;
                    r_c_lo   <= w_is_add ? bus.alu_carry : 1'b0;
                    r_alu_a  <= r_a[15:8];
                    r_alu_b  <= r_b[15:8];
                    r_state  <= S_HI;
                end
                S_HI: begin
                    r_c_hi <= bus.alu_carry;
                    if (w_need_fix) begin
                        r_state  <= S_FIX;
                        r_alu_a  <= bus.alu_res;
                        r_alu_b  <= 8'h01;
                        r_alu_op <= OP_SUM;
                    end else begin
                        r_state     <= S_RESP;
                        r_alu_a     <= 8'h00;
                        r_alu_b     <= 8'h00;
                        r_alu_op    <= OP_SUM;
                        r_rsp_valid <= 1'b1;
                        r_rsp_res   <= w_res;
                        r_rsp_pc    <= w_pc;
                        r_rsp_carry <= w_carry;
                        r_rsp_ovf   <= w_ovf;
                    end
                end
                S_FIX: begin
                    r_c_hi      <= w_c_hi;
                    r_state     <= S_RESP;
                    r_alu_a     <= 8'h00;
                    r_alu_b     <= 8'h00;
                    r_alu_op    <= OP_SUM;
                    r_rsp_valid <= 1'b1;
                    r_rsp_res   <= w_res;
                    r_rsp_pc    <= w_pc;
                    r_rsp_carry <= w_carry;
                    r_rsp_ovf   <= w_ovf;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_res   <= 16'h0000;
                        r_rsp_pc    <= 1'b0;
                        r_rsp_carry <= 1'b0;
                        r_rsp_ovf   <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_res        = r_rsp_res;
    assign bus.rsp_page_cross = r_rsp_pc;
    assign bus.rsp_carry      = r_rsp_carry;
    assign bus.rsp_ovf        = r_rsp_ovf;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.alu_a          = r_alu_a;
    assign bus.alu_b          = r_alu_b;
    assign bus.alu_op         = r_alu_op;
endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed cases, reset-in-flight, then
// random commands compared against a plain 16-bit arithmetic reference.
module tb_alu_seq16;
    localparam logic [4:0] OP_SUM = 5'b10000;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b00100;
    localparam logic [4:0] OP_EOR = 5'b00010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq16_if bus();
    alu_seq16 u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Byte ALU attached to the sequencer; SUM ignores any carry-in.
    always_comb begin
        bus.alu_res   = 8'h00;
        bus.alu_carry = 1'b0;
        case (bus.alu_op)
            OP_SUM:  {bus.alu_carry, bus.alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OP_AND:  bus.alu_res = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_res = bus.alu_a | bus.alu_b;
            OP_EOR:  bus.alu_res = bus.alu_a ^ bus.alu_b;
            default: bus.alu_res = 8'h00;
        endcase
    end

    int n_vec = 0;
    int n_mis = 0;
    logic [15:0] obs_res;
    logic        obs_pc, obs_cy, obs_ov, obs_er;
    logic [20:0] tr [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic pc, output logic cy,
                         output logic ov, output logic er, output int lat,
                         output logic [15:0] bx, output logic [4:0] op);
        logic [16:0] s;
        logic        lo_carry;
        bx  = (cmd == 3'd1) ? {{8{b[7]}}, b[7:0]} : b;
        lo_carry = (({1'b0, a[7:0]} + {1'b0, bx[7:0]}) > 9'd255);
        res = 16'h0000; pc = 1'b0; cy = 1'b0; ov = 1'b0; er = 1'b0; lat = 2; op = OP_SUM;
        case (cmd)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, bx};
                res = s[15:0];
                cy  = s[16];
                pc  = lo_carry;
                ov  = (a[15] == bx[15]) && (res[15] != a[15]);
                lat = lo_carry ? 3 : 2;
            end
            3'd1: begin
                res = a + bx;
                pc  = (res[15:8] != a[15:8]);
                lat = lo_carry ? 3 : 2;
            end
            3'd2: begin res = a & b; op = OP_AND; end
            3'd3: begin res = a | b; op = OP_OR;  end
            3'd4: begin res = a ^ b; op = OP_EOR; end
            default: begin res = 16'hFFFF; er = 1'b1; lat = 0; end
        endcase
    endtask

    // One full transaction starting at a negedge; ends at the negedge after the handshake.
    task automatic do_txn(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        logic [15:0] e_res, bx;
        logic        e_pc, e_cy, e_ov, e_er;
        logic [4:0]  op;
        logic [7:0]  pre_hi;
        int          lat, w, cnt;
        model(cmd, a, b, e_res, e_pc, e_cy, e_ov, e_er, lat, bx, op);
        pre_hi = a[15:8] + bx[15:8];
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'($urandom);
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        @(negedge clk);
        cnt = 0;
        while (bus.rsp_valid !== 1'b1 && cnt < 8) begin
            tr[cnt] = {bus.alu_a, bus.alu_b, bus.alu_op};
            bus.rsp_ready = 1'($urandom);
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, lat);
        if (!e_er) begin
            check("alu_lo_pass", tr[0], {a[7:0], bx[7:0], op});
            check("alu_hi_pass", tr[1], {a[15:8], bx[15:8], op});
            if (lat == 3) check("alu_fix_pass", tr[2], {pre_hi, 8'h01, OP_SUM});
        end
        obs_res = bus.rsp_res;
        obs_pc  = bus.rsp_page_cross;
        obs_cy  = bus.rsp_carry;
        obs_ov  = bus.rsp_ovf;
        obs_er  = bus.rsp_err;
        check("rsp_res", obs_res, e_res);
        check("rsp_flags", {obs_pc, obs_cy, obs_ov, obs_er}, {e_pc, e_cy, e_ov, e_er});
        check("alu_idle_in_resp", {bus.alu_a, bus.alu_b, bus.alu_op}, {16'h0000, OP_SUM});
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid_ready", {bus.rsp_valid, bus.req_ready}, 2'b10);
            check("hold_rsp", {bus.rsp_res, bus.rsp_page_cross, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err},
                  {e_res, e_pc, e_cy, e_ov, e_er});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'($urandom);
        check("post_handshake", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'd0;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {bus.req_ready, bus.rsp_valid, bus.rsp_res, bus.rsp_err, bus.alu_op},
              {1'b0, 1'b0, 16'h0000, 1'b0, OP_SUM});
        rst = 1'b0;
        @(negedge clk);

        do_txn(3'd0, 16'h1234, 16'h0011, 0);
        check("add_1234_res", {obs_res, obs_pc, obs_cy, obs_ov}, {16'h1245, 3'b000});
        do_txn(3'd0, 16'h12F0, 16'h0020, 1);
        check("add_12f0_res", {obs_res, obs_pc, obs_cy, obs_ov}, {16'h1310, 3'b100});
        do_txn(3'd0, 16'hFFFF, 16'h0001, 0);
        check("add_ffff_res", {obs_res, obs_pc, obs_cy, obs_ov}, {16'h0000, 3'b110});
        do_txn(3'd0, 16'h7FFF, 16'h0001, 0);
        check("add_7fff_res", {obs_res, obs_cy, obs_ov}, {16'h8000, 2'b01});
        do_txn(3'd1, 16'h0280, 16'hABFE, 0);
        check("addrel_back", {obs_res, obs_pc, obs_cy, obs_ov}, {16'h027E, 3'b000});
        do_txn(3'd1, 16'h0200, 16'h1280, 2);
        check("addrel_cross", {obs_res, obs_pc, obs_cy, obs_ov}, {16'h0180, 3'b100});
        do_txn(3'd4, 16'hF0F0, 16'hFF00, 5);
        check("eor_res", {obs_res, obs_pc, obs_cy, obs_ov, obs_er}, {16'h0FF0, 4'b0000});
        do_txn(3'd6, 16'h1111, 16'h2222, 3);
        check("invalid_cmd", {obs_res, obs_er}, {16'hFFFF, 1'b1});

        // Reset while the high-byte pass is in progress drops the command.
        while (bus.req_ready !== 1'b1) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'd0;
        bus.req_a     = 16'h12F0;
        bus.req_b     = 16'h0020;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_hi", {bus.req_ready, bus.rsp_valid, bus.rsp_res, bus.rsp_page_cross,
                              bus.rsp_carry, bus.rsp_ovf, bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_op},
              {1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000, OP_SUM});
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_rsp_after_drop", bus.rsp_valid, 1'b0);
        end
        check("ready_after_drop", bus.req_ready, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] cmd;
            cmd = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            do_txn(cmd, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
